spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transaction, MSB first, SCK half-period of CLK_DIV sys_clk cycles.
// All bus-facing outputs come straight from flops; timing is counted from the edge that accepts start.
//
//   state | meaning
//   IDLE  | bus released, waiting for start
//   SETUP | CS_N low, first MOSI bit driven, waiting for the first SCK rise
//   SHIFT | toggling SCK; sample MISO on rises, advance MOSI on falls
//   HOLD  | SCK low after the 8th fall, CS_N still asserted
//   GAP   | CS_N high, busy still set before returning to IDLE
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] txd_data,
    input  logic       MISO,
    output logic       CS_N,
    output logic       SCK,
    output logic       MOSI,
    output logic [7:0] rxd_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t     state, state_nxt;
    logic [7:0] div_cnt, div_nxt;
    logic [3:0] bit_cnt, bit_nxt;
    logic [7:0] tx_sr, tx_nxt;
    logic [7:0] rx_sr, rx_nxt;
    logic [7:0] rxd_nxt;
    logic       cs_n_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic       tick, launch;

    assign tick = (div_cnt == 8'(CLK_DIV - 1));
    // A start held through the end of GAP relaunches on that same edge, giving
    // back-to-back transactions a period of exactly 18 half-periods.
    assign launch = start && ((state == IDLE) || (state == GAP && tick));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 4'd0;
            tx_sr    <= 8'd0;
            rx_sr    <= 8'd0;
            rxd_data <= 8'd0;
            CS_N     <= 1'b1;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            tx_sr    <= tx_nxt;
            rx_sr    <= rx_nxt;
            rxd_data <= rxd_nxt;
            CS_N     <= cs_n_nxt;
            SCK      <= sck_nxt;
            MOSI     <= mosi_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = tick ? 8'd0 : div_cnt + 8'd1;
        bit_nxt   = bit_cnt;
        tx_nxt    = tx_sr;
        rx_nxt    = rx_sr;
        rxd_nxt   = rxd_data;
        cs_n_nxt  = CS_N;
        sck_nxt   = SCK;
        mosi_nxt  = MOSI;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                div_nxt = 8'd0;
            end
            SETUP, SHIFT: begin
                if (tick) begin
                    if (!SCK) begin
                        sck_nxt   = 1'b1;
                        rx_nxt    = {rx_sr[6:0], MISO};
                        bit_nxt   = bit_cnt + 4'd1;
                        state_nxt = SHIFT;
                    end else begin
                        sck_nxt = 1'b0;
                        if (bit_cnt == 4'd8) begin
                            state_nxt = HOLD;
                        end else begin
                            tx_nxt   = {tx_sr[6:0], 1'b0};
                            mosi_nxt = tx_sr[6];
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_nxt  = 1'b1;
                    mosi_nxt  = 1'b0;
                    rxd_nxt   = rx_sr;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (launch) begin
            tx_nxt    = txd_data;
            rx_nxt    = 8'd0;
            cs_n_nxt  = 1'b0;
            sck_nxt   = 1'b0;
            mosi_nxt  = txd_data[7];
            busy_nxt  = 1'b1;
            div_nxt   = 8'd0;
            bit_nxt   = 4'd0;
            state_nxt = SETUP;
        end
    end

endmodule
